writeback_unit: RTL and testbench

Result write-back path for the dual-issue core: it accepts up to two 16-bit results per cycle from the execute stage and buffers them in order. It retires them into the data memory's write ports, at most two per cycle, and never writes the same address twice in one cycle. It is the write-side counterpart of the fetch path that reads operands out of the same data memory.

---
 rtl/wb_pkg.sv | 11 +
 rtl/wb_queue.sv | 65 ++++++
 rtl/writeback_unit.sv | 118 +++++++++++
 tb/tb_writeback_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and entry type for the result write-back path.
package wb_pkg;
  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DEPTH  = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// Dual-push / dual-pop circular buffer of {addr, data} entries with head, tail and count.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push0,
  input  logic                      i_push1,
  input  logic [ADDR_W-1:0]         i_addr0,
  input  logic [ADDR_W-1:0]         i_addr1,
  input  logic [DATA_W-1:0]         i_data0,
  input  logic [DATA_W-1:0]         i_data1,
  input  logic [1:0]                i_pop,
  output logic [ADDR_W-1:0]         o_addr [DEPTH],
  output logic [DATA_W-1:0]         o_data [DEPTH],
  output logic [$clog2(DEPTH)-1:0]  o_head,
  output logic [$clog2(DEPTH):0]    o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     w_tail1;
  logic [1:0]        w_npush;

  // A lone lane-1 push lands at tail, otherwise right after lane 0.
  assign w_npush = {1'b0, i_push0} + {1'b0, i_push1};
  assign w_tail1 = r_tail + PW'(i_push0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PW'(w_npush);
      r_head  <= r_head + PW'(i_pop);
      r_count <= r_count + CW'(w_npush) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push0) begin
      r_addr[r_tail] <= i_addr0;
      r_data[r_tail] <= i_data0;
    end
    if (i_push1) begin
      r_addr[w_tail1] <= i_addr1;
      r_data[w_tail1] <= i_data1;
    end
  end

  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_head  = r_head;
  assign o_count = r_count;
endmodule

// File: rtl/writeback_unit.sv
// Dual-issue result write-back: in-order queue drained into two memory write ports.
// Optional WB_BYPASS_EN adds a combinational lookup of pending results (lk_* ports).
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                    clk,
  input  logic                    preset,
  input  logic [1:0]              res_valid,
  input  logic [ADDR_W-1:0]       res_addr0,
  input  logic [ADDR_W-1:0]       res_addr1,
  input  logic [DATA_W-1:0]       res_data0,
  input  logic [DATA_W-1:0]       res_data1,
  output logic                    res_ready,
  input  logic                    mem_busy,
  output logic [1:0]              mem_we,
  output logic [ADDR_W-1:0]       mem_waddr0,
  output logic [ADDR_W-1:0]       mem_waddr1,
  output logic [DATA_W-1:0]       mem_wdata0,
  output logic [DATA_W-1:0]       mem_wdata1,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    ovf
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]       lk_addr0,
  input  logic [ADDR_W-1:0]       lk_addr1,
  output logic [1:0]              lk_hit,
  output logic [DATA_W-1:0]       lk_data0,
  output logic [DATA_W-1:0]       lk_data1
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] w_addr [DEPTH];
  logic [DATA_W-1:0] w_data [DEPTH];
  logic [PW-1:0]     w_head;
  logic [PW-1:0]     w_head1;
  logic [CW-1:0]     w_count;
  logic [1:0]        w_acc;
  logic              w_we0;
  logic              w_we1;
  logic [1:0]        w_pop;
  logic              r_ovf;

  wb_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (preset),
    .i_push0 (w_acc[0]),
    .i_push1 (w_acc[1]),
    .i_addr0 (res_addr0),
    .i_addr1 (res_addr1),
    .i_data0 (res_data0),
    .i_data1 (res_data1),
    .i_pop   (w_pop),
    .o_addr  (w_addr),
    .o_data  (w_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Ready looks at occupancy before this cycle's pop so it never depends on mem_busy.
  assign res_ready = (CW'(DEPTH) - w_count) >= CW'(2);
  assign w_acc     = res_valid & {2{res_ready}};

  assign w_head1 = w_head + PW'(1);
  assign w_we0   = !mem_busy && (w_count != '0);
  // Same-address pair is split across cycles so the younger value lands last.
  assign w_we1   = w_we0 && (w_count >= CW'(2)) && (w_addr[w_head1] != w_addr[w_head]);
  assign w_pop   = {1'b0, w_we0} + {1'b0, w_we1};

  assign mem_we     = {w_we1, w_we0};
  assign mem_waddr0 = w_we0 ? w_addr[w_head]  : '0;
  assign mem_wdata0 = w_we0 ? w_data[w_head]  : '0;
  assign mem_waddr1 = w_we1 ? w_addr[w_head1] : '0;
  assign mem_wdata1 = w_we1 ? w_data[w_head1] : '0;

  always_ff @(posedge clk) begin
    if (preset) begin
      r_ovf <= 1'b0;
    end else if ((res_valid != 2'b00) && !res_ready) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf   = r_ovf;
  assign count = w_count;
  assign empty = (w_count == '0);

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    lk_hit   = 2'b00;
    lk_data0 = '0;
    lk_data1 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < w_count) begin
        if (w_addr[w_head + PW'(k)] == lk_addr0) begin
          lk_hit[0] = 1'b1;
          lk_data0  = w_data[w_head + PW'(k)];
        end
        if (w_addr[w_head + PW'(k)] == lk_addr1) begin
          lk_hit[1] = 1'b1;
          lk_data1  = w_data[w_head + PW'(k)];
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes accepted results, a negedge monitor checks writes.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int DEPTH = WB_DEPTH;

  logic        clk = 1'b0;
  logic        preset;
  logic [1:0]  res_valid;
  logic [4:0]  res_addr0, res_addr1;
  logic [15:0] res_data0, res_data1;
  logic        res_ready;
  logic        mem_busy;
  logic [1:0]  mem_we;
  logic [4:0]  mem_waddr0, mem_waddr1;
  logic [15:0] mem_wdata0, mem_wdata1;
  logic [2:0]  count;
  logic        empty;
  logic        ovf;
`ifdef WB_BYPASS_EN
  logic [4:0]  lk_addr0, lk_addr1;
  logic [1:0]  lk_hit;
  logic [15:0] lk_data0, lk_data1;
  logic        e_h0, e_h1;
  logic [15:0] e_d0, e_d1;
`endif

  always #5 clk = ~clk;

  writeback_unit #(.DATA_W(16), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .preset     (preset),
    .res_valid  (res_valid),
    .res_addr0  (res_addr0),
    .res_addr1  (res_addr1),
    .res_data0  (res_data0),
    .res_data1  (res_data1),
    .res_ready  (res_ready),
    .mem_busy   (mem_busy),
    .mem_we     (mem_we),
    .mem_waddr0 (mem_waddr0),
    .mem_waddr1 (mem_waddr1),
    .mem_wdata0 (mem_wdata0),
    .mem_wdata1 (mem_wdata1),
    .count      (count),
    .empty      (empty),
    .ovf        (ovf)
`ifdef WB_BYPASS_EN
    ,
    .lk_addr0   (lk_addr0),
    .lk_addr1   (lk_addr1),
    .lk_hit     (lk_hit),
    .lk_data0   (lk_data0),
    .lk_data1   (lk_data1)
`endif
  );

  // Reference model: pending results in program order, plus the sticky overflow flag.
  wb_entry_t   exp_q[$];
  bit          m_ovf = 1'b0;
  logic [15:0] dut_mem [32];
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares the current cycle's outputs, then retires the entries written.
  int         sz;
  logic [1:0] exp_we;
  always @(negedge clk) begin
    if (!preset) begin
      sz = exp_q.size();
      chk("count", 32'(count), 32'(sz));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("res_ready", 32'(res_ready), 32'((DEPTH - sz) >= 2));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      exp_we = 2'b00;
      if (!mem_busy && sz > 0) begin
        exp_we[0] = 1'b1;
        if (sz >= 2 && exp_q[0].addr != exp_q[1].addr) exp_we[1] = 1'b1;
      end
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we[0]) begin
        chk("waddr0", 32'(mem_waddr0), 32'(exp_q[0].addr));
        chk("wdata0", 32'(mem_wdata0), 32'(exp_q[0].data));
      end else begin
        chk("waddr0_idle", 32'({mem_waddr0, mem_wdata0}), 32'(0));
      end
      if (exp_we[1]) begin
        chk("waddr1", 32'(mem_waddr1), 32'(exp_q[1].addr));
        chk("wdata1", 32'(mem_wdata1), 32'(exp_q[1].data));
      end else begin
        chk("waddr1_idle", 32'({mem_waddr1, mem_wdata1}), 32'(0));
      end
`ifdef WB_BYPASS_EN
      e_h0 = 1'b0; e_h1 = 1'b0; e_d0 = '0; e_d1 = '0;
      foreach (exp_q[k]) begin
        if (exp_q[k].addr == lk_addr0) begin e_h0 = 1'b1; e_d0 = exp_q[k].data; end
        if (exp_q[k].addr == lk_addr1) begin e_h1 = 1'b1; e_d1 = exp_q[k].data; end
      end
      chk("lk_hit", 32'(lk_hit), 32'({e_h1, e_h0}));
      if (e_h0) chk("lk_data0", 32'(lk_data0), 32'(e_d0));
      if (e_h1) chk("lk_data1", 32'(lk_data1), 32'(e_d1));
`endif
      if (mem_we[0]) dut_mem[mem_waddr0] = mem_wdata0;
      if (mem_we[1]) dut_mem[mem_waddr1] = mem_wdata1;
      if (exp_we[0]) void'(exp_q.pop_front());
      if (exp_we[1]) void'(exp_q.pop_front());
    end
  end

  // One clock of stimulus; acceptance follows the conservative free-slot rule.
  task automatic step(input logic [1:0] v, input logic [4:0] a0, input logic [15:0] d0,
                      input logic [4:0] a1, input logic [15:0] d1,
                      input logic busy, input logic rst);
    bit rdy;
    res_valid = v; res_addr0 = a0; res_data0 = d0;
    res_addr1 = a1; res_data1 = d1;
    mem_busy = busy; preset = rst;
    rdy = (DEPTH - exp_q.size()) >= 2;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (v != 2'b00 && !rdy) m_ovf = 1'b1;
      if (rdy && v[0]) exp_q.push_back('{addr: a0, data: d0});
      if (rdy && v[1]) exp_q.push_back('{addr: a1, data: d1});
    end
    #1;
  endtask

  task automatic idle(input int n, input logic busy);
    for (int i = 0; i < n; i++) step(2'b00, 5'd0, 16'd0, 5'd0, 16'd0, busy, 1'b0);
  endtask

  initial begin
    preset = 1'b1; mem_busy = 1'b0; res_valid = 2'b00;
    res_addr0 = '0; res_addr1 = '0; res_data0 = '0; res_data1 = '0;
    for (int i = 0; i < 32; i++) dut_mem[i] = 16'h0;
`ifdef WB_BYPASS_EN
    lk_addr0 = 5'd31; lk_addr1 = 5'd30;
`endif
    #1;
    step(2'b00, 0, 0, 0, 0, 1'b0, 1'b1);
    step(2'b00, 0, 0, 0, 0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Two distinct addresses retire together the next cycle.
    step(2'b11, 5'd3, 16'h1111, 5'd4, 16'h2222, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Same-address pair is split; the younger value is left in memory.
    step(2'b11, 5'd7, 16'hAAAA, 5'd7, 16'hBBBB, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("mem7_final", 32'(dut_mem[7]), 32'h0000BBBB);

    // Fill under mem_busy, overflow, then stream 16 results across the wrap.
    step(2'b11, 5'd8, 16'h0808, 5'd9, 16'h0909, 1'b1, 1'b0);
    step(2'b11, 5'd10, 16'h0A0A, 5'd11, 16'h0B0B, 1'b1, 1'b0);
    step(2'b01, 5'd12, 16'h0C0C, 5'd0, 16'h0, 1'b1, 1'b0);
    idle(2, 1'b1);
    idle(1, 1'b0);
    for (int i = 0; i < 8; i++)
      step(2'b11, 5'(2 * i), 16'(16'h5000 + 2 * i), 5'(2 * i + 1), 16'(16'h5001 + 2 * i), 1'b0, 1'b0);
    idle(3, 1'b0);
    for (int i = 0; i < 16; i++) chk("stream_mem", 32'(dut_mem[i]), 32'(16'h5000 + i));

    // Reset with entries pending discards them.
    step(2'b11, 5'd20, 16'hDEAD, 5'd21, 16'hBEEF, 1'b1, 1'b0);
    step(2'b00, 0, 0, 0, 0, 1'b0, 1'b1);
    idle(3, 1'b0);
    chk("no_stale_20", 32'(dut_mem[20]), 32'h0);

`ifdef WB_BYPASS_EN
    lk_addr0 = 5'd5; lk_addr1 = 5'd9;
    step(2'b11, 5'd5, 16'h1234, 5'd5, 16'h5678, 1'b1, 1'b0);
    idle(2, 1'b1);
    idle(3, 1'b0);
`endif

    // Randomised traffic with narrow address range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
`ifdef WB_BYPASS_EN
      lk_addr0 = 5'($urandom_range(0, 7));
      lk_addr1 = 5'($urandom_range(0, 7));
`endif
      step(2'($urandom), 5'($urandom_range(0, 7)), 16'($urandom),
           5'($urandom_range(0, 7)), 16'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 59) == 0));
    end
    idle(8, 1'b0);
    chk("final_count", 32'(count), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
